// File: rtl/us_tlp_tx_engine_pkg.sv
// Shared command codes, entry field offsets, TLP constants and FSM states for
// the upstream TLP transmit engine.
package us_tlp_tx_engine_pkg;

   localparam logic [1:0] US_CMD_INVALID   = 2'd0;
   localparam logic [1:0] US_CMD_WR32_TYPE = 2'd1;
   localparam logic [1:0] US_CMD_CPL_TYPE  = 2'd2;
   localparam logic [1:0] US_CMD_CPLD_TYPE = 2'd3;

   // Bit offsets inside the low 64 bits of a command FIFO entry
   localparam int ENT_TYPE_LSB = 62;
   localparam int ENT_LEN_LSB  = 57;
   localparam int ENT_ID_LSB   = 55;
   localparam int ENT_TC_LSB   = 52;
   localparam int ENT_TD_BIT   = 51;
   localparam int ENT_EP_BIT   = 50;
   localparam int ENT_ATTR_LSB = 48;
   localparam int ENT_RID_LSB  = 22;
   localparam int ENT_TAG_LSB  = 14;
   localparam int ENT_ADDR_LSB = 0;

   localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
   localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
   localparam logic [4:0] TLP_TYPE_CPL   = 5'b01010;
   localparam logic [4:0] TLP_TYPE_MWR   = 5'b00000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_HDR2,
      ST_DATA,
      ST_DONE
   } tx_state_e;

   // Payload size in DW for a MWr32, with the exponent clamped to max_log2
   function automatic logic [10:0] calc_ndw(input logic [4:0] len, input logic [4:0] max_log2);
      logic [4:0] eff;
      eff = (len > max_log2) ? max_log2 : len;
      return 11'd1 << eff;
   endfunction

endpackage

// File: rtl/us_tlp_hdr_gen.sv
// Combinational 3DW TLP header generator: selects DW0..DW2 of a CPL, CPLD or
// MWr32 header from the latched command entry.
module us_tlp_hdr_gen
   import us_tlp_tx_engine_pkg::*;
#(
   parameter int MAX_LEN_LOG2 = 5
) (
   input  logic [63:0] entry_i,
   input  logic [15:0] completer_id_i,
   input  logic [1:0]  beat_idx_i,
   output logic [31:0] hdr_o
);

   localparam logic [4:0] MAX_LOG2_W = MAX_LEN_LOG2[4:0];

   logic [1:0]  cmd_type;
   logic [10:0] ndw;
   logic [1:0]  cpl_fmt;
   logic [9:0]  cpl_len;
   logic [3:0]  last_be;
   logic        unused_bits;

   assign cmd_type = entry_i[ENT_TYPE_LSB +: 2];
   assign ndw      = calc_ndw(entry_i[ENT_LEN_LSB +: 5], MAX_LOG2_W);
   assign cpl_fmt  = (cmd_type == US_CMD_CPLD_TYPE) ? FMT_3DW_DATA : FMT_3DW_NODATA;
   assign cpl_len  = (cmd_type == US_CMD_CPLD_TYPE) ? 10'd1 : 10'd0;
   assign last_be  = (ndw == 11'd1) ? 4'h0 : 4'hF;

   // cmd_id, requested length, byte enables and the low address bits never reach a header
   assign unused_bits = ^{entry_i[ENT_ID_LSB +: 2], entry_i[47:38], entry_i[13:6], entry_i[1:0]};

   always_comb begin
      hdr_o = '0;
      if (cmd_type == US_CMD_WR32_TYPE) begin
         case (beat_idx_i)
            2'd0:    hdr_o = {1'b0, FMT_3DW_DATA, TLP_TYPE_MWR, 1'b0, 3'b000, 4'b0000,
                              1'b0, 1'b0, 2'b00, 2'b00, ndw[9:0]};
            2'd1:    hdr_o = {completer_id_i, 8'h00, last_be, 4'hF};
            2'd2:    hdr_o = {entry_i[31:2], 2'b00};
            default: hdr_o = '0;
         endcase
      end else begin
         case (beat_idx_i)
            2'd0:    hdr_o = {1'b0, cpl_fmt, TLP_TYPE_CPL, 1'b0, entry_i[ENT_TC_LSB +: 3], 4'b0000,
                              entry_i[ENT_TD_BIT], entry_i[ENT_EP_BIT], entry_i[ENT_ATTR_LSB +: 2],
                              2'b00, cpl_len};
            2'd1:    hdr_o = {completer_id_i, 3'b000, 1'b0, 12'd4};
            2'd2:    hdr_o = {entry_i[ENT_RID_LSB +: 16], entry_i[ENT_TAG_LSB +: 8], 1'b0,
                              1'b0, entry_i[ENT_ADDR_LSB + 2 +: 4], 2'b00};
            default: hdr_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/us_tlp_tx_engine.sv
// Pops upstream commands from a FWFT FIFO and emits CPL / CPLD / MWr32 TLPs on a
// 32-bit AXI4-Stream TX port; pulses a completion when each MWr32 finishes.
module us_tlp_tx_engine
   import us_tlp_tx_engine_pkg::*;
#(
   parameter int          MAX_LEN_LOG2 = 5,
   parameter logic [31:0] PATTERN_INIT = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] us_cmd_fifo_dout_i,
   input  logic         us_cmd_fifo_empty_i,
   output logic         us_cmd_fifo_rd_en_o,
   input  logic [15:0]  cfg_completer_id_i,
   output logic [10:0]  rd_addr_o,
   input  logic [31:0]  rd_data_i,
   output logic [31:0]  s_axis_tx_tdata_o,
   output logic [3:0]   s_axis_tx_tkeep_o,
   output logic         s_axis_tx_tvalid_o,
   output logic         s_axis_tx_tlast_o,
   input  logic         s_axis_tx_tready_i,
   output logic         up_wr_cmd_compl_o,
   output logic [1:0]   up_wr_cmd_id_o,
   output logic         busy_o
);

   localparam logic [4:0] MAX_LOG2_W = MAX_LEN_LOG2[4:0];

   // AXI-Stream handshake: a beat transfers on a cycle with tvalid && tready;
   // while tvalid is high, tdata/tlast hold until that transfer happens.

   tx_state_e   state_q, state_d;
   logic [63:0] entry_q, entry_d;
   logic [10:0] beat_q, beat_d;
   logic [31:0] pattern_q, pattern_d;

   logic [1:0]  cur_type;
   logic [10:0] ndw;
   logic [1:0]  hdr_idx;
   logic [31:0] hdr_word;
   logic        wr_last;
   logic        unused_fifo_bits;

   assign unused_fifo_bits = ^us_cmd_fifo_dout_i[127:64];

   assign cur_type = entry_q[ENT_TYPE_LSB +: 2];
   assign ndw      = calc_ndw(entry_q[ENT_LEN_LSB +: 5], MAX_LOG2_W);
   assign wr_last  = (beat_q == ndw - 11'd1);

   always_comb begin
      case (state_q)
         ST_HDR1: hdr_idx = 2'd1;
         ST_HDR2: hdr_idx = 2'd2;
         default: hdr_idx = 2'd0;
      endcase
   end

   us_tlp_hdr_gen #(
      .MAX_LEN_LOG2 (MAX_LEN_LOG2)
   ) u_hdr_gen (
      .entry_i        (entry_q),
      .completer_id_i (cfg_completer_id_i),
      .beat_idx_i     (hdr_idx),
      .hdr_o          (hdr_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         entry_q   <= '0;
         beat_q    <= '0;
         pattern_q <= PATTERN_INIT;
      end else begin
         state_q   <= state_d;
         entry_q   <= entry_d;
         beat_q    <= beat_d;
         pattern_q <= pattern_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      entry_d             = entry_q;
      beat_d              = beat_q;
      pattern_d           = pattern_q;
      us_cmd_fifo_rd_en_o = 1'b0;
      rd_addr_o           = '0;
      s_axis_tx_tdata_o   = '0;
      s_axis_tx_tvalid_o  = 1'b0;
      s_axis_tx_tlast_o   = 1'b0;
      up_wr_cmd_compl_o   = 1'b0;
      up_wr_cmd_id_o      = '0;

      case (state_q)
         ST_IDLE: begin
            if (!us_cmd_fifo_empty_i) begin
               us_cmd_fifo_rd_en_o = 1'b1;
               // An INVALID head is popped and discarded without leaving IDLE
               if (us_cmd_fifo_dout_i[ENT_TYPE_LSB +: 2] != US_CMD_INVALID) begin
                  entry_d = us_cmd_fifo_dout_i[63:0];
                  state_d = ST_HDR0;
               end
            end
         end
         ST_HDR0: begin
            s_axis_tx_tvalid_o = 1'b1;
            s_axis_tx_tdata_o  = hdr_word;
            if (s_axis_tx_tready_i) state_d = ST_HDR1;
         end
         ST_HDR1: begin
            s_axis_tx_tvalid_o = 1'b1;
            s_axis_tx_tdata_o  = hdr_word;
            if (s_axis_tx_tready_i) state_d = ST_HDR2;
         end
         ST_HDR2: begin
            s_axis_tx_tvalid_o = 1'b1;
            s_axis_tx_tdata_o  = hdr_word;
            s_axis_tx_tlast_o  = (cur_type == US_CMD_CPL_TYPE);
            if (s_axis_tx_tready_i) begin
               beat_d  = '0;
               state_d = (cur_type == US_CMD_CPL_TYPE) ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            s_axis_tx_tvalid_o = 1'b1;
            if (cur_type == US_CMD_CPLD_TYPE) begin
               rd_addr_o         = {7'd0, entry_q[ENT_ADDR_LSB + 2 +: 4]};
               s_axis_tx_tdata_o = rd_data_i;
               s_axis_tx_tlast_o = 1'b1;
               if (s_axis_tx_tready_i) state_d = ST_IDLE;
            end else begin
               s_axis_tx_tdata_o = pattern_q;
               s_axis_tx_tlast_o = wr_last;
               if (s_axis_tx_tready_i) begin
                  pattern_d = pattern_q + 32'd1;
                  beat_d    = beat_q + 11'd1;
                  if (wr_last) state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            up_wr_cmd_compl_o = 1'b1;
            up_wr_cmd_id_o    = entry_q[ENT_ID_LSB +: 2];
            state_d           = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign s_axis_tx_tkeep_o = 4'hF;
   assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_us_tlp_tx_engine.sv
// Bench for us_tlp_tx_engine: FIFO and register-file models, beat/completion
// monitors, and a field-level TLP reference model fed by directed and random commands.
module tb_us_tlp_tx_engine;

   localparam int          MAX_LEN_LOG2 = 5;
   localparam logic [31:0] PATTERN_INIT = 32'h0000_0000;

   logic         clk;
   logic         rst;
   logic [127:0] fifo_dout;
   logic         fifo_empty;
   logic         rd_en;
   logic [15:0]  cid;
   logic [10:0]  rd_addr;
   logic [31:0]  rd_data;
   logic [31:0]  tdata;
   logic [3:0]   tkeep;
   logic         tvalid;
   logic         tlast;
   logic         tready;
   logic         compl;
   logic [1:0]   compl_id;
   logic         busy;

   us_tlp_tx_engine #(
      .MAX_LEN_LOG2 (MAX_LEN_LOG2),
      .PATTERN_INIT (PATTERN_INIT)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .us_cmd_fifo_dout_i  (fifo_dout),
      .us_cmd_fifo_empty_i (fifo_empty),
      .us_cmd_fifo_rd_en_o (rd_en),
      .cfg_completer_id_i  (cid),
      .rd_addr_o           (rd_addr),
      .rd_data_i           (rd_data),
      .s_axis_tx_tdata_o   (tdata),
      .s_axis_tx_tkeep_o   (tkeep),
      .s_axis_tx_tvalid_o  (tvalid),
      .s_axis_tx_tlast_o   (tlast),
      .s_axis_tx_tready_i  (tready),
      .up_wr_cmd_compl_o   (compl),
      .up_wr_cmd_id_o      (compl_id),
      .busy_o              (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(negedge clk) cyc++;

   // ---------------- FIFO and register-file models ----------------
   logic [127:0] fifo_q[$];
   bit           pop_pending = 0;
   int           pop_cnt = 0;
   int           rd_en_empty_err = 0;
   logic [31:0]  regs [16];

   assign rd_data = (rd_addr[10:4] == 7'd0) ? regs[rd_addr[3:0]] : 32'hBAD0_BAD0;

   task automatic fifo_refresh();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = fifo_empty ? '0 : fifo_q[0];
   endtask

   task automatic fifo_push(input logic [127:0] e);
      fifo_q.push_back(e);
      fifo_refresh();
   endtask

   always @(posedge clk) begin
      if (rd_en) begin
         pop_cnt++;
         pop_pending = 1;
         if (fifo_empty) rd_en_empty_err++;
      end
   end

   always @(negedge clk) begin
      if (pop_pending) begin
         pop_pending = 0;
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         fifo_refresh();
      end
   end

   // 0: always ready, 1: toggle, 2: random
   int tready_mode = 0;
   always @(negedge clk) begin
      case (tready_mode)
         0:       tready = 1'b1;
         1:       tready = ~tready;
         default: tready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- monitors ----------------
   logic [32:0] cap_q[$];
   logic [1:0]  capc_q[$];
   int          gap_q[$];
   int          last_tlast_cyc = 0;
   int          stall_err = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_data;
   logic        prev_last;

   always @(posedge clk) begin
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && !(tvalid === 1'b1 && tdata === prev_data && tlast === prev_last))
            stall_err++;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         if (tvalid && tready) begin
            cap_q.push_back({tlast, tdata});
            if (tlast) last_tlast_cyc = cyc;
         end
         if (compl) begin
            capc_q.push_back(compl_id);
            gap_q.push_back(cyc - last_tlast_cyc);
         end
      end
   end

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [32:0] exp_q[$];
   logic [1:0]  expc_q[$];
   logic [31:0] model_pattern = PATTERN_INIT;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk_cpl(input logic [1:0] typ, input logic [1:0] id,
                                           input logic [2:0] tc, input logic td, input logic ep,
                                           input logic [1:0] attr, input logic [15:0] rid,
                                           input logic [7:0] tag, input logic [5:0] addr);
      logic [127:0] e;
      e = '0;
      e[127:96] = $urandom;
      e[63:62]  = typ;
      e[56:55]  = id;
      e[54:52]  = tc;
      e[51]     = td;
      e[50]     = ep;
      e[49:48]  = attr;
      e[47:38]  = 10'($urandom);
      e[37:22]  = rid;
      e[21:14]  = tag;
      e[13:6]   = 8'($urandom);
      e[5:0]    = addr;
      return e;
   endfunction

   function automatic logic [127:0] mk_wr(input logic [4:0] len, input logic [1:0] id,
                                          input logic [31:0] addr);
      logic [127:0] e;
      e = '0;
      e[63:62] = 2'd1;
      e[61:57] = len;
      e[56:55] = id;
      e[31:0]  = addr;
      return e;
   endfunction

   // Reference model: the TLP each entry must produce, built from the field rules
   task automatic model_cmd(input logic [127:0] e);
      logic [1:0]  typ;
      logic [31:0] dw0, dw1, dw2, n;
      int          l;
      typ = e[63:62];
      if (typ == 2'd0) return;
      if (typ >= 2'd2) begin
         dw0 = (32'(typ == 2'd3 ? 2 : 0) << 29) | (32'h0A << 24) | (32'(e[54:52]) << 20)
             | (32'(e[51]) << 15) | (32'(e[50]) << 14) | (32'(e[49:48]) << 12)
             | (typ == 2'd3 ? 32'd1 : 32'd0);
         dw1 = (32'(cid) << 16) | 32'd4;
         dw2 = (32'(e[37:22]) << 16) | (32'(e[21:14]) << 8) | (32'(e[5:0]) & 32'h3C);
         exp_q.push_back({1'b0, dw0});
         exp_q.push_back({1'b0, dw1});
         exp_q.push_back({typ == 2'd2, dw2});
         if (typ == 2'd3) exp_q.push_back({1'b1, regs[e[5:2]]});
      end else begin
         l   = int'(e[61:57]);
         if (l > MAX_LEN_LOG2) l = MAX_LEN_LOG2;
         n   = 32'd1 << l;
         dw0 = 32'h4000_0000 | (n & 32'h3FF);
         dw1 = (32'(cid) << 16) | (n == 1 ? 32'h0F : 32'hFF);
         dw2 = e[31:0] & 32'hFFFF_FFFC;
         exp_q.push_back({1'b0, dw0});
         exp_q.push_back({1'b0, dw1});
         exp_q.push_back({1'b0, dw2});
         for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({i == int'(n) - 1, model_pattern});
            model_pattern++;
         end
         expc_q.push_back(e[56:55]);
      end
   endtask

   task automatic push_cmd(input logic [127:0] e, input bit use_model);
      fifo_push(e);
      if (use_model) model_cmd(e);
   endtask

   task automatic wait_and_compare(input string tag);
      int budget;
      budget = 5000;
      while (budget > 0 && !(fifo_q.size() == 0 && !pop_pending && !busy
                             && cap_q.size() >= exp_q.size())) begin
         @(negedge clk); #1;
         budget--;
      end
      check({tag, "_done_in_time"}, 64'(budget > 0), 64'd1);
      check({tag, "_beat_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < cap_q.size()) check($sformatf("%s_beat%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
      check({tag, "_compl_count"}, 64'(capc_q.size()), 64'(expc_q.size()));
      for (int i = 0; i < expc_q.size(); i++) begin
         if (i < capc_q.size()) begin
            check($sformatf("%s_compl_id%0d", tag, i), 64'(capc_q[i]), 64'(expc_q[i]));
            check($sformatf("%s_compl_gap%0d", tag, i), 64'(gap_q[i]), 64'd1);
         end
      end
      check({tag, "_stall_stable"}, 64'(stall_err), 64'd0);
      cap_q.delete();
      exp_q.delete();
      capc_q.delete();
      expc_q.delete();
      gap_q.delete();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int          pops0;
      int          budget;
      logic [1:0]  typ;
      int          nb;

      rst    = 1'b1;
      tready = 1'b1;
      cid    = 16'h0200;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      regs[4] = 32'hDEAD_BEEF;
      fifo_refresh();

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tkeep", 64'(tkeep), 64'hF);
      check("rst_tdata", 64'(tdata), 64'd0);
      check("rst_tlast", 64'(tlast), 64'd0);
      check("rst_rd_en", 64'(rd_en), 64'd0);
      check("rst_compl", 64'({compl, compl_id}), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("idle_empty_no_pop", 64'(pop_cnt), 64'd0);

      // CPL
      fifo_push(mk_cpl(2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 2'b00, 16'h0100, 8'h05, 6'h08));
      exp_q.push_back({1'b0, 32'h0A00_0000});
      exp_q.push_back({1'b0, 32'h0200_0004});
      exp_q.push_back({1'b1, 32'h0100_0508});
      wait_and_compare("cpl");

      // CPLD reading register 4
      fifo_push(mk_cpl(2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 2'b00, 16'h0100, 8'h05, 6'h10));
      exp_q.push_back({1'b0, 32'h4A00_0001});
      exp_q.push_back({1'b0, 32'h0200_0004});
      exp_q.push_back({1'b0, 32'h0100_0510});
      exp_q.push_back({1'b1, 32'hDEAD_BEEF});
      wait_and_compare("cpld");

      // MWr32 of 4 DW
      fifo_push(mk_wr(5'd2, 2'd1, 32'h1000_0040));
      exp_q.push_back({1'b0, 32'h4000_0004});
      exp_q.push_back({1'b0, 32'h0200_00FF});
      exp_q.push_back({1'b0, 32'h1000_0040});
      for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 32'(i)});
      expc_q.push_back(2'd1);
      wait_and_compare("mwr_len2");
      model_pattern = 32'd4;

      // clamped length under alternating backpressure
      tready_mode = 1;
      push_cmd(mk_wr(5'd6, 2'd2, 32'h2000_0100), 1);
      wait_and_compare("mwr_clamp");
      tready_mode = 0;

      // INVALID, CPL, single-DW MWr32 queued back to back
      pops0 = pop_cnt;
      @(negedge clk); #1;
      push_cmd(mk_cpl(2'd0, 2'd3, 3'd7, 1'b1, 1'b1, 2'b11, 16'hFFFF, 8'hFF, 6'h3F), 1);
      push_cmd(mk_cpl(2'd2, 2'd0, 3'd5, 1'b1, 1'b0, 2'b10, 16'hABCD, 8'h77, 6'h2C), 1);
      push_cmd(mk_wr(5'd0, 2'd3, 32'h3000_0007), 1);
      wait_and_compare("b2b");
      check("b2b_pop_count", 64'(pop_cnt - pops0), 64'd3);

      // reset during the third data beat of an MWr32
      push_cmd(mk_wr(5'd3, 2'd3, 32'h4000_0000), 1);
      budget = 1000;
      while (budget > 0 && cap_q.size() < 5) begin
         @(negedge clk); #1;
         budget--;
      end
      check("rst_mid_reached_data", 64'(budget > 0), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_tvalid", 64'(tvalid), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_mid_no_compl", 64'(capc_q.size()), 64'd0);
      check("rst_mid_beats_truncated", 64'(cap_q.size()), 64'd5);
      cap_q.delete();
      exp_q.delete();
      expc_q.delete();
      capc_q.delete();
      gap_q.delete();
      model_pattern = PATTERN_INIT;
      push_cmd(mk_wr(5'd1, 2'd2, 32'h5000_0010), 1);
      wait_and_compare("after_rst");

      // random batches with random backpressure
      tready_mode = 2;
      for (int b = 0; b < 6; b++) begin
         cid = 16'($urandom);
         nb  = $urandom_range(1, 5);
         for (int k = 0; k < nb; k++) begin
            typ = 2'($urandom_range(0, 3));
            if (typ == 2'd1)
               push_cmd(mk_wr(5'($urandom_range(0, 7)), 2'($urandom), $urandom), 1);
            else
               push_cmd(mk_cpl(typ, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                               2'($urandom), 16'($urandom), 8'($urandom), 6'($urandom)), 1);
         end
         wait_and_compare($sformatf("rand%0d", b));
      end
      tready_mode = 0;

      check("rd_en_while_empty", 64'(rd_en_empty_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
